// File: rtl/pb_debounce.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pb_debounce
// Push-button conditioner: synchronizes a raw bouncing button line, qualifies
// press/release edges over DB_CYCLES stable samples, and emits one-cycle ticks
// for each accepted press plus optional auto-repeat ticks while held.
//
// Ports
//   clk         in   single rising-edge clock
//   rst         in   asynchronous active-high reset
//   PB          in   raw asynchronous push-button line
//   tick        out  one-cycle pulse per accepted press / repeat
//   level       out  debounced button state, 1 = pressed
//   rep_active  out  high while auto-repeat is running
// -----------------------------------------------------------------------------
module pb_debounce #(
    parameter int unsigned DB_CYCLES     = 16,
    parameter int unsigned REP_EN        = 1,
    parameter int unsigned REP_DELAY     = 400,
    parameter int unsigned REP_RATE      = 100,
    parameter int unsigned PB_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic PB,
    output logic tick,
    output logic level,
    output logic rep_active
);

    // Idle (not pressed) level of the raw line; synchronizer resets to it so
    // reset release never looks like a press edge.
    localparam logic        RELEASED   = (PB_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic        REP_ON     = (REP_EN != 0);
    localparam logic [15:0] DB_LAST    = 16'(DB_CYCLES - 1);
    localparam logic [15:0] DELAY_LAST = 16'(REP_DELAY - 1);
    localparam logic [15:0] RATE_LAST  = 16'(REP_RATE - 1);
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_PRESS_CHK   = 3'd1;
    localparam logic [2:0] S_HOLD        = 3'd2;
    localparam logic [2:0] S_REPEAT      = 3'd3;
    localparam logic [2:0] S_RELEASE_CHK = 3'd4;

    logic [1:0]  sync_q;
    logic        raw_s;
    logic [2:0]  state_q, state_d;
    logic [15:0] db_cnt_q, db_cnt_d;
    logic [15:0] rep_cnt_q, rep_cnt_d;
    logic [15:0] rep_limit;
    logic        tick_q, tick_d;
    logic        level_q, level_d;
    logic        rep_act_q, rep_act_d;

    // Two-flop synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {RELEASED, RELEASED};
        else     sync_q <= {sync_q[0], PB};
    end

    // Normalize to active-high pressed
    assign raw_s = sync_q[1] ^ RELEASED;

    // First repeat waits REP_DELAY, later ones REP_RATE
    assign rep_limit = (state_q == S_REPEAT) ? RATE_LAST : DELAY_LAST;

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rep_cnt_d = rep_cnt_q;
        tick_d    = 1'b0;
        level_d   = level_q;
        rep_act_d = rep_act_q;
        case (state_q)
            S_IDLE: begin
                level_d   = 1'b0;
                rep_act_d = 1'b0;
                if (raw_s) begin
                    state_d  = S_PRESS_CHK;
                    db_cnt_d = '0;
                end
            end
            S_PRESS_CHK: begin
                if (!raw_s) begin
                    // bounce: restart qualification from scratch
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d   = S_HOLD;
                    level_d   = 1'b1;
                    tick_d    = 1'b1;
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 16'd1;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (!raw_s) begin
                    // this low sample is the first of the release window;
                    // repeat counter stays frozen meanwhile
                    state_d  = S_RELEASE_CHK;
                    db_cnt_d = 16'd1;
                end else if (REP_ON && (rep_cnt_q >= rep_limit)) begin
                    state_d   = S_REPEAT;
                    rep_act_d = 1'b1;
                    tick_d    = 1'b1;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q != CNT_MAX) begin
                    rep_cnt_d = rep_cnt_q + 16'd1;
                end
            end
            S_RELEASE_CHK: begin
                if (raw_s) begin
                    // release bounce: go back where we came from, no new press
                    state_d  = rep_act_q ? S_REPEAT : S_HOLD;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d   = S_IDLE;
                    level_d   = 1'b0;
                    rep_act_d = 1'b0;
                    db_cnt_d  = '0;
                    rep_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                db_cnt_d  = '0;
                rep_cnt_d = '0;
                level_d   = 1'b0;
                rep_act_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            tick_q    <= 1'b0;
            level_q   <= 1'b0;
            rep_act_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
            rep_act_q <= rep_act_d;
        end
    end

    assign tick       = tick_q;
    assign level      = level_q;
    assign rep_active = rep_act_q;

endmodule

// File: doc/pb_debounce.md
PB_DEBOUNCE -- requirements
Module: pb_debounce

Interface
REQ-001 Parameter DB_CYCLES, default 16, is the number of consecutive stable synchronized samples needed to accept a level change (range 2..65535).
REQ-002 Parameter REP_EN, default 1, enables auto-repeat while the button is held (0 = single tick per press).
REQ-003 Parameter REP_DELAY, default 400, is the number of cycles from the press tick to the first repeat tick (range 2..65535).
REQ-004 Parameter REP_RATE, default 100, is the number of cycles between later repeat ticks (range 2..65535).
REQ-005 Parameter PB_ACTIVE_LOW, default 1: 1 means PB=0 is pressed; 0 means PB=1 is pressed.
REQ-006 clk  input  1  the single clock; all flops are rising-edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 PB  input  1  raw, asynchronous, bouncing push-button line.
REQ-009 tick  output  1  one-cycle pulse per accepted press and per repeat; drives the count-enable input of the downstream BCD counter.
REQ-010 level  output  1  debounced button state, 1 = pressed.
REQ-011 rep_active  output  1  high while the block is in REPEAT.

Function
REQ-012 PB shall pass through a two-flop synchronizer and then be normalized to active-high (raw_s); raw_s is the only input to the logic below.
REQ-013 The state machine shall have the states IDLE, PRESS_CHK, HOLD, REPEAT and RELEASE_CHK.
REQ-014 IDLE: raw_s=1 moves to PRESS_CHK with the stability counter cleared; level=0.
REQ-015 PRESS_CHK: the counter shall increment each cycle raw_s=1, and a cycle with raw_s=0 shall return to IDLE with the counter cleared (a bounce restarts the qualification).
REQ-016 When the counter reaches DB_CYCLES, the FSM shall go to HOLD, set level=1 and assert tick for exactly that one cycle.
REQ-017 Press latency: DB_CYCLES+3 rising edges from a clean PB assertion to tick high (2 synchronizer edges, DB_CYCLES qualification samples, 1 registered output).
REQ-018 HOLD: a repeat counter shall start at 0 on the press-tick cycle; if REP_EN=1 and the counter reaches REP_DELAY-1 with raw_s still 1, the FSM shall go to REPEAT and assert tick, so the first repeat tick comes REP_DELAY cycles after the press tick.
REQ-019 REPEAT: tick shall assert every REP_RATE cycles while pressed, and rep_active shall be 1 throughout.
REQ-020 In HOLD or REPEAT, raw_s=0 shall go to RELEASE_CHK, freeze the repeat counter and suppress tick.
REQ-021 RELEASE_CHK: DB_CYCLES consecutive samples of raw_s=0 shall go to IDLE with level=0 and rep_active=0.
REQ-022 In RELEASE_CHK, raw_s=1 shall return to the state held before RELEASE_CHK (HOLD or REPEAT), resume the repeat counter from its frozen value and emit no extra press tick.
REQ-023 If REP_EN=0, HOLD shall never go to REPEAT, giving exactly one tick per accepted press.
REQ-024 Counters shall saturate and never wrap; the repeat counter shall reload to 0 on each repeat tick.
REQ-025 tick, level and rep_active shall be driven directly from flops, with no combinational path from PB.
REQ-026 tick shall never be high on two consecutive cycles.

Reset
REQ-027 When rst is asserted, state shall be IDLE, all counters 0, and tick=0, level=0, rep_active=0.
REQ-028 When rst is asserted, both synchronizer flops shall load the released value (1 if PB_ACTIVE_LOW=1, else 0).
REQ-029 Reset asserted mid-press shall abort immediately with no tick.
REQ-030 After reset deasserts with the button already held, a full press qualification (REQ-017) is required before tick.
REQ-031 Reset deassertion is synchronized externally; the block shall need no extra release logic.

Verification (DB_CYCLES=4, REP_DELAY=10, REP_RATE=3, PB_ACTIVE_LOW=1)
REQ-032 Clean press: PB falls at edge 0 and holds low for 8 cycles -> tick high only at edge 7; level=1 from edge 7; REP_EN=0 run shows no further ticks.
REQ-033 Bounce: PB low 3 cycles, high 1, low 6 -> exactly one tick, at the 4th consecutive low sample plus 3 edges; a 3-cycle glitch alone gives no tick and level stays 0.
REQ-034 Auto-repeat: hold 40 cycles after the press tick at cycle T -> ticks at T, T+10, T+13, T+16, ..., T+37; rep_active=1 from T+10.
REQ-035 Release bounce in REPEAT: PB high 2 cycles then low again -> no tick during the gap, repeat phase resumes with no press tick; a later release of 4 or more cycles gives level=0 and rep_active=0.
REQ-036 Reset mid-operation: rst pulsed in REPEAT -> all outputs 0 asynchronously, before the next clock edge; PB still held after release -> next tick DB_CYCLES+3 edges later.
REQ-037 Integration: 25 clean presses feed a BCD 00-99 counter -> counter reads 25; a single held press with REP_EN=0 -> counter advances by 1.
